// File: rtl/upd_grad_acc.sv
// upd_grad_acc
//   Weight-gradient accumulator for the update stage. For every (cell, input)
//   pair it sums TIMESTEP products d*x, each rescaled by >>> FRAC. It then
//   saturates the sum to WIDTH bits and emits it with its dW/dU write address.
//   Gradients leave in cell-major order.
// Ports
//   clk      clock, rising edge
//   rst      asynchronous active-high reset
//   en       block enable; low aborts (FSM to IDLE, counters/acc/pipe cleared)
//   i_valid  i_d / i_x carry a valid operand pair
//   i_d      d-gate operand (signed)
//   i_x      x/h operand (signed)
//   o_grad   saturated gradient, held between strobes
//   o_addr   cell*NUM_INPUT + input, held between strobes
//   o_valid  one-cycle strobe for o_grad / o_addr
//   o_done   one-cycle strobe together with the final o_valid
//   o_busy   high while accumulating (ACC state)
module upd_grad_acc #(
  parameter int WIDTH      = 16,
  parameter int FRAC       = 12,
  parameter int TIMESTEP   = 7,
  parameter int NUM_CELL   = 8,
  parameter int NUM_INPUT  = 8,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    i_valid,
  input  logic signed [WIDTH-1:0] i_d,
  input  logic signed [WIDTH-1:0] i_x,
  output logic [WIDTH-1:0]        o_grad,
  output logic [ADDR_WIDTH-1:0]   o_addr,
  output logic                    o_valid,
  output logic                    o_done,
  output logic                    o_busy
);

  localparam int PW    = 2 * WIDTH;
  localparam int ACC_W = 2 * WIDTH + 4;
  localparam int TW    = (TIMESTEP  > 1) ? $clog2(TIMESTEP)  : 1;
  localparam int IW    = (NUM_INPUT > 1) ? $clog2(NUM_INPUT) : 1;
  localparam int CW    = (NUM_CELL  > 1) ? $clog2(NUM_CELL)  : 1;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (WIDTH - 1)) - 1);
  // Two's complement: ~max == -max-1 == most negative WIDTH-bit value.
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t state, state_next;

  logic [TW-1:0] t_cnt;
  logic [IW-1:0] in_cnt;
  logic [CW-1:0] cell_cnt;

  logic accept;
  logic t_last, in_last, cell_last, last_grad;
  logic [ADDR_WIDTH-1:0] addr_cur;

  // Stage 1 registers
  logic                  v1;
  logic                  first1;
  logic                  last1;
  logic                  done1;
  logic signed [PW-1:0]  prod;
  logic [ADDR_WIDTH-1:0] addr1;

  // Stage 2
  logic signed [PW-1:0]    p;
  logic signed [ACC_W-1:0] p_ext;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_sum;
  logic [WIDTH-1:0]        sat;

  assign t_last    = (t_cnt == TW'(TIMESTEP - 1));
  assign in_last   = (in_cnt == IW'(NUM_INPUT - 1));
  assign cell_last = (cell_cnt == CW'(NUM_CELL - 1));
  assign last_grad = t_last && in_last && cell_last;
  assign addr_cur  = ADDR_WIDTH'(cell_cnt * NUM_INPUT + in_cnt);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state;
    if (!en) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    state_next = ACC;
        ACC:     if (accept && last_grad) state_next = DONE;
        DONE:    state_next = DONE;
        default: state_next = IDLE;
      endcase
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    o_busy = (state == ACC);
    accept = en && i_valid && (state == ACC);
  end

  // ---------------- sample / pair counters ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_cnt    <= '0;
      in_cnt   <= '0;
      cell_cnt <= '0;
    end else if (!en) begin
      t_cnt    <= '0;
      in_cnt   <= '0;
      cell_cnt <= '0;
    end else if (accept) begin
      if (t_last) begin
        t_cnt <= '0;
        if (in_last) begin
          in_cnt   <= '0;
          cell_cnt <= cell_last ? '0 : cell_cnt + 1'b1;
        end else begin
          in_cnt <= in_cnt + 1'b1;
        end
      end else begin
        t_cnt <= t_cnt + 1'b1;
      end
    end
  end

  // ---------------- stage 1: multiply ----------------
  // The address is constant across one pair's samples, so the address captured
  // with the first sample equals the one re-captured with every sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1     <= 1'b0;
      first1 <= 1'b0;
      last1  <= 1'b0;
      done1  <= 1'b0;
      prod   <= '0;
      addr1  <= '0;
    end else if (!en) begin
      v1     <= 1'b0;
      first1 <= 1'b0;
      last1  <= 1'b0;
      done1  <= 1'b0;
    end else begin
      v1 <= accept;
      if (accept) begin
        prod   <= i_d * i_x;
        first1 <= (t_cnt == '0);
        last1  <= t_last;
        done1  <= last_grad;
        addr1  <= addr_cur;
      end
    end
  end

  // ---------------- stage 2: scale, accumulate, saturate ----------------
  always_comb begin
    p       = prod >>> FRAC;
    p_ext   = {{(ACC_W - PW){p[PW-1]}}, p};
    acc_sum = (first1 ? '0 : acc) + p_ext;
    if (acc_sum > SAT_MAX)
      sat = {1'b0, {(WIDTH - 1){1'b1}}};
    else if (acc_sum < SAT_MIN)
      sat = {1'b1, {(WIDTH - 1){1'b0}}};
    else
      sat = acc_sum[WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      o_grad  <= '0;
      o_addr  <= '0;
      o_valid <= 1'b0;
      o_done  <= 1'b0;
    end else if (!en) begin
      acc     <= '0;
      o_valid <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      o_valid <= v1 && last1;
      o_done  <= v1 && last1 && done1;
      if (v1) acc <= acc_sum;
      if (v1 && last1) begin
        o_grad <= sat;
        o_addr <= addr1;
      end
    end
  end

endmodule

// File: tb/tb_upd_grad_acc.sv
module tb_upd_grad_acc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic en1 = 1'b0;
  logic i_valid = 1'b0;
  logic signed [15:0] i_d = '0;
  logic signed [15:0] i_x = '0;

  logic [15:0] o_grad, o1_grad;
  logic [11:0] o_addr, o1_addr;
  logic o_valid, o_done, o_busy;
  logic o1_valid, o1_done, o1_busy;

  always #5 clk = ~clk;

  upd_grad_acc dut (
    .clk(clk), .rst(rst), .en(en), .i_valid(i_valid), .i_d(i_d), .i_x(i_x),
    .o_grad(o_grad), .o_addr(o_addr), .o_valid(o_valid), .o_done(o_done),
    .o_busy(o_busy)
  );

  upd_grad_acc #(.NUM_CELL(1), .NUM_INPUT(1)) dut1 (
    .clk(clk), .rst(rst), .en(en1), .i_valid(i_valid), .i_d(i_d), .i_x(i_x),
    .o_grad(o1_grad), .o_addr(o1_addr), .o_valid(o1_valid), .o_done(o1_done),
    .o_busy(o1_busy)
  );

  typedef struct {
    logic [15:0] g;
    logic [11:0] a;
    logic        dn;
    int          cyc;
  } strobe_t;

  typedef struct {
    logic signed [15:0] d;
    logic signed [15:0] x;
    logic [15:0]        exp_grad;
  } vec_t;

  strobe_t q0[$];
  strobe_t q1[$];
  strobe_t s0, s1;
  int cyc = 0;
  int last_cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_valid) begin
      s0.g = o_grad; s0.a = o_addr; s0.dn = o_done; s0.cyc = cyc;
      q0.push_back(s0);
      $display("dut  strobe addr=%0d grad=%0d done=%0b", o_addr, $signed(o_grad), o_done);
    end
    if (o1_valid) begin
      s1.g = o1_grad; s1.a = o1_addr; s1.dn = o1_done; s1.cyc = cyc;
      q1.push_back(s1);
      $display("dut1 strobe addr=%0d grad=%0d done=%0b", o1_addr, $signed(o1_grad), o1_done);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pop one strobe from the main DUT queue and compare it.
  task automatic pop_chk(input string tag, input int exp_addr,
                         input logic [15:0] exp_g, input logic exp_dn);
    strobe_t s;
    if (q0.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s missing: got no strobe expected addr %0d", tag, exp_addr);
      return;
    end
    s = q0.pop_front();
    chk({tag, " addr"}, 32'(s.a), 32'(exp_addr));
    chk({tag, " grad"}, 32'(s.g), 32'(exp_g));
    chk({tag, " done"}, 32'(s.dn), 32'(exp_dn));
  endtask

  // Drive TIMESTEP samples of one pair; optional idle cycle after each sample.
  task automatic send(input logic signed [15:0] d, input logic signed [15:0] x, input bit gap);
    for (int t = 0; t < 7; t++) begin
      @(posedge clk); #1;
      i_valid = 1'b1; i_d = d; i_x = x;
      last_cyc = cyc;
      if (gap) begin
        @(posedge clk); #1;
        i_valid = 1'b0;
      end
    end
  endtask

  task automatic idle_in(input int n);
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sweep(input bit gap);
    for (int c = 0; c < 8; c++)
      for (int i = 0; i < 8; i++)
        send(16'(c * 512), 16'((i + 1) * 256), gap);
    idle_in(4);
  endtask

  task automatic check_sweep(input string tag);
    int e;
    chk({tag, " count"}, 32'(q0.size()), 32'd64);
    for (int k = 0; k < 64; k++) begin
      e = 7 * (((k / 8) * 512 * ((k % 8) + 1) * 256) >>> 12);
      pop_chk(tag, k, 16'(e), k == 63);
    end
  endtask

  // Restart the main DUT from any state: one cycle with en low, then en high.
  task automatic restart();
    @(posedge clk); #1; en = 1'b0;
    @(posedge clk); #1; en = 1'b1;
    @(posedge clk); #1;
  endtask

  vec_t tbl[8];

  initial begin
    tbl[0] = '{16'sh7FFF, 16'sh7FFF, 16'h7FFF};  // positive saturation
    tbl[1] = '{16'sh8000, 16'sh7FFF, 16'h8000};  // negative saturation
    tbl[2] = '{16'shFFFF, 16'sh0001, 16'hFFF9};  // -1 per sample, floor
    tbl[3] = '{16'sh1000, 16'sh1000, 16'h7000};  // 1.0*1.0*7
    tbl[4] = '{16'sh1000, 16'shF000, 16'h9000};  // -28672
    tbl[5] = '{16'sh0003, 16'sh0555, 16'h0000};  // 4095>>>12 = 0
    tbl[6] = '{16'sh8000, 16'sh8000, 16'h7FFF};  // 2^30 product, saturates
    tbl[7] = '{16'shFFFD, 16'sh0555, 16'hFFF9};  // -4095>>>12 = -1

    repeat (3) @(posedge clk);
    #1;
    chk("reset o_valid", 32'(o_valid), 32'd0);
    chk("reset o_grad",  32'(o_grad),  32'd0);
    chk("reset o_addr",  32'(o_addr),  32'd0);
    chk("reset o_busy",  32'(o_busy),  32'd0);
    chk("reset o_done",  32'(o_done),  32'd0);
    rst = 1'b0;

    // Single-gradient instance: 7 x (1.0 * 1.0)
    @(posedge clk); #1; en1 = 1'b1;
    @(posedge clk); #1;
    chk("t1 busy", 32'(o1_busy), 32'd1);
    send(16'sh1000, 16'sh1000, 1'b0);
    idle_in(4);
    chk("t1 count", 32'(q1.size()), 32'd1);
    if (q1.size() != 0) begin
      s1 = q1.pop_front();
      chk("t1 grad", 32'(s1.g), 32'd28672);
      chk("t1 addr", 32'(s1.a), 32'd0);
      chk("t1 done", 32'(s1.dn), 32'd1);
      chk("t1 latency", 32'(s1.cyc - last_cyc), 32'd2);
    end
    chk("t1 busy after done", 32'(o1_busy), 32'd0);
    chk("t1 main idle", 32'(q0.size()), 32'd0);

    // Table vectors as consecutive gradients, then abort in the middle of the next pair
    @(posedge clk); #1; en = 1'b1;
    @(posedge clk); #1;
    for (int v = 0; v < 8; v++) send(tbl[v].d, tbl[v].x, 1'b0);
    for (int t = 0; t < 3; t++) begin
      @(posedge clk); #1;
      i_valid = 1'b1; i_d = 16'sh1000; i_x = 16'sh1000;
    end
    @(posedge clk); #1;
    i_valid = 1'b0; en = 1'b0;
    idle_in(4);
    chk("tbl count", 32'(q0.size()), 32'd8);
    for (int v = 0; v < 8; v++) pop_chk($sformatf("tbl[%0d]", v), v, tbl[v].exp_grad, 1'b0);
    chk("abort busy", 32'(o_busy), 32'd0);

    // Full continuous sweep after re-enable restarts at address 0
    @(posedge clk); #1; en = 1'b1;
    @(posedge clk); #1;
    sweep(1'b0);
    check_sweep("sweep");
    chk("sweep busy after done", 32'(o_busy), 32'd0);

    // DONE ignores further operands
    send(16'sh1000, 16'sh1000, 1'b0);
    idle_in(4);
    chk("done ignores input", 32'(q0.size()), 32'd0);

    // Gapped sweep
    restart();
    sweep(1'b1);
    check_sweep("gapped");

    // Asynchronous reset while o_valid is high
    restart();
    send(16'sh1000, 16'sh1000, 1'b0);
    @(posedge clk); #1;
    i_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre-rst o_valid", 32'(o_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("async rst o_valid", 32'(o_valid), 32'd0);
    chk("async rst o_grad",  32'(o_grad),  32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_in(3);
    chk("async rst no strobe", 32'(q0.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Absolute watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
